// File: rtl/uart_pack_assembler.sv
// Collects UART bytes into one output/frequency/ctrl/period pack and presents
// it downstream over valid/ready, dropping partial packs on inter-byte timeout.
module uart_pack_assembler #(
  parameter int DATA_BIT        = 32,
  parameter int TIMEOUT_CLK     = 100000,
  parameter int LOW_PERIOD_CLK  = 20,
  parameter int HIGH_PERIOD_CLK = 5
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [7:0]          data_i,
  input  logic                rx_done_tick_i,
  input  logic                ready_i,
  output logic                valid_o,
  output logic [DATA_BIT-1:0] output_pattern_o,
  output logic [DATA_BIT-1:0] freq_pattern_o,
  output logic [7:0]          ctrl_o,
  output logic [7:0]          high_period_o,
  output logic [7:0]          low_period_o,
  output logic                timeout_tick_o,
  output logic                overrun_tick_o
);

  localparam int NB       = DATA_BIT / 8;
  localparam int PACK_NUM = NB * 2 + 3;
  localparam int CW       = $clog2(PACK_NUM + 1);
  localparam int TW       = $clog2(TIMEOUT_CLK);
  localparam logic [CW-1:0] LAST_IDX = CW'(PACK_NUM - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CLK - 1);
  localparam logic [7:0]    HIGH_DFLT = 8'(HIGH_PERIOD_CLK);
  localparam logic [7:0]    LOW_DFLT  = 8'(LOW_PERIOD_CLK);

  // DONE is the one-cycle commit slot between the last byte and valid_o rising.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    DONE = 2'd2,
    HOLD = 2'd3
  } state_t;

  function automatic logic [7:0] subst_zero(input logic [7:0] b, input logic [7:0] dflt);
    subst_zero = (b == 8'd0) ? dflt : b;
  endfunction

  state_t        state_r, next_s;
  logic [CW-1:0] byte_cnt_r, cnt_next_s, store_idx_s;
  logic [TW-1:0] to_cnt_r, to_next_s;
  logic [7:0]    shadow_r [PACK_NUM];
  logic          store_s, commit_s, release_s, timeout_s, overrun_s;
  logic [DATA_BIT-1:0] pat_s, freq_s;

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_s;
    end
  end

  // Next-state logic and datapath strobes.
  always_comb begin
    next_s      = state_r;
    cnt_next_s  = byte_cnt_r;
    to_next_s   = to_cnt_r;
    store_idx_s = byte_cnt_r;
    store_s     = 1'b0;
    commit_s    = 1'b0;
    release_s   = 1'b0;
    timeout_s   = 1'b0;
    overrun_s   = 1'b0;
    case (state_r)
      IDLE: begin
        to_next_s = {TW{1'b0}};
        if (rx_done_tick_i) begin
          store_s     = 1'b1;
          store_idx_s = {CW{1'b0}};
          cnt_next_s  = CW'(1);
          next_s      = RECV;
        end else begin
          cnt_next_s = {CW{1'b0}};
        end
      end
      RECV: begin
        if (rx_done_tick_i) begin
          store_s   = 1'b1;
          to_next_s = {TW{1'b0}};
          if (byte_cnt_r == LAST_IDX) begin
            next_s = DONE;
          end else begin
            cnt_next_s = byte_cnt_r + CW'(1);
          end
        end else if (to_cnt_r == TO_LAST) begin
          timeout_s  = 1'b1;
          to_next_s  = {TW{1'b0}};
          cnt_next_s = {CW{1'b0}};
          next_s     = IDLE;
        end else begin
          to_next_s = to_cnt_r + TW'(1);
        end
      end
      DONE: begin
        commit_s   = 1'b1;
        cnt_next_s = {CW{1'b0}};
        next_s     = HOLD;
        overrun_s  = rx_done_tick_i;
      end
      HOLD: begin
        if (ready_i) begin
          release_s = 1'b1;
          if (rx_done_tick_i) begin
            store_s     = 1'b1;
            store_idx_s = {CW{1'b0}};
            cnt_next_s  = CW'(1);
            next_s      = RECV;
          end else begin
            next_s = IDLE;
          end
        end else begin
          overrun_s = rx_done_tick_i;
        end
      end
      default: begin
        next_s     = IDLE;
        cnt_next_s = {CW{1'b0}};
        to_next_s  = {TW{1'b0}};
      end
    endcase
  end

  // Multi-byte fields are assembled LSB byte first from the shadow buffer.
  always_comb begin
    pat_s  = {DATA_BIT{1'b0}};
    freq_s = {DATA_BIT{1'b0}};
    for (int i = 0; i < NB; i++) begin
      pat_s[8*i +: 8]  = shadow_r[i];
      freq_s[8*i +: 8] = shadow_r[NB+i];
    end
  end

  // Shadow buffer, counters and registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < PACK_NUM; i++) begin
        shadow_r[i] <= 8'd0;
      end
      byte_cnt_r       <= {CW{1'b0}};
      to_cnt_r         <= {TW{1'b0}};
      valid_o          <= 1'b0;
      output_pattern_o <= {DATA_BIT{1'b0}};
      freq_pattern_o   <= {DATA_BIT{1'b0}};
      ctrl_o           <= 8'd0;
      high_period_o    <= 8'd0;
      low_period_o     <= 8'd0;
      timeout_tick_o   <= 1'b0;
      overrun_tick_o   <= 1'b0;
    end else begin
      byte_cnt_r     <= cnt_next_s;
      to_cnt_r       <= to_next_s;
      timeout_tick_o <= timeout_s;
      overrun_tick_o <= overrun_s;
      if (store_s) begin
        shadow_r[store_idx_s] <= data_i;
      end else begin
        shadow_r[store_idx_s] <= shadow_r[store_idx_s];
      end
      if (commit_s) begin
        valid_o          <= 1'b1;
        output_pattern_o <= pat_s;
        freq_pattern_o   <= freq_s;
        ctrl_o           <= shadow_r[2*NB];
        high_period_o    <= subst_zero(shadow_r[2*NB+1], HIGH_DFLT);
        low_period_o     <= subst_zero(shadow_r[2*NB+2], LOW_DFLT);
      end else if (release_s) begin
        valid_o <= 1'b0;
      end else begin
        valid_o <= valid_o;
      end
    end
  end

endmodule

// File: tb/tb_uart_pack_assembler.sv
// Randomized self-checking bench for uart_pack_assembler against a byte-level
// reference model of the pack layout and handshake.
module tb_uart_pack_assembler;

  localparam int DATA_BIT = 32;
  localparam int TO_CLK   = 200;
  localparam int PN       = 11;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic [7:0]  data = 8'd0;
  logic        tick = 1'b0;
  logic        ready = 1'b0;
  logic        valid;
  logic [31:0] out_pat, freq_pat;
  logic [7:0]  ctrl, hi, lo;
  logic        to_tick, ov_tick;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0]  pk [PN];
  logic [31:0] cur_out, cur_freq;
  logic [7:0]  cur_ctrl, cur_hi, cur_lo;

  uart_pack_assembler #(
    .DATA_BIT(DATA_BIT), .TIMEOUT_CLK(TO_CLK), .LOW_PERIOD_CLK(20), .HIGH_PERIOD_CLK(5)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni), .data_i(data), .rx_done_tick_i(tick), .ready_i(ready),
    .valid_o(valid), .output_pattern_o(out_pat), .freq_pattern_o(freq_pat),
    .ctrl_o(ctrl), .high_period_o(hi), .low_period_o(lo),
    .timeout_tick_o(to_tick), .overrun_tick_o(ov_tick)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  task automatic check_fields(input string tag);
    check_eq({tag, "_out"},  64'(out_pat),  64'(cur_out));
    check_eq({tag, "_freq"}, 64'(freq_pat), 64'(cur_freq));
    check_eq({tag, "_ctrl"}, 64'(ctrl),     64'(cur_ctrl));
    check_eq({tag, "_hi"},   64'(hi),       64'(cur_hi));
    check_eq({tag, "_lo"},   64'(lo),       64'(cur_lo));
  endtask

  // Reference: fields are little-endian byte sums; zero periods take defaults.
  task automatic model_pack();
    cur_out  = 32'd0;
    cur_freq = 32'd0;
    for (int i = 0; i < 4; i++) begin
      cur_out  += 32'(pk[i])   * (32'd1 << (8*i));
      cur_freq += 32'(pk[4+i]) * (32'd1 << (8*i));
    end
    cur_ctrl = pk[8];
    cur_hi   = (pk[9]  == 8'd0) ? 8'd5  : pk[9];
    cur_lo   = (pk[10] == 8'd0) ? 8'd20 : pk[10];
  endtask

  task automatic rand_pack();
    for (int i = 0; i < PN; i++) pk[i] = 8'($urandom);
    if ($urandom_range(0, 3) == 0) pk[9] = 8'd0;
    if ($urandom_range(0, 3) == 0) pk[10] = 8'd0;
  endtask

  // Returns at the falling edge right after the edge that sampled the tick.
  task automatic send_byte(input logic [7:0] b, input int gap);
    @(negedge clk);
    data = b;
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_pack(input int start, input logic rdy, input string tag);
    ready = rdy;
    for (int i = start; i < PN; i++) begin
      if (i == PN - 1) check_eq({tag, "_valid_pre"}, 64'(valid), 64'd0);
      send_byte(pk[i], (i == PN - 1) ? 0 : $urandom_range(0, 3));
    end
    @(negedge clk);
    check_eq({tag, "_valid"}, 64'(valid), 64'd1);
    check_fields(tag);
    if (rdy) begin
      @(negedge clk);
      check_eq({tag, "_valid_clr"}, 64'(valid), 64'd0);
    end
  endtask

  initial begin
    int first_n, pulses, bad, ov_cnt;

    repeat (3) @(negedge clk);
    check_eq("rst_valid", 64'(valid), 64'd0);
    check_eq("rst_ticks", 64'({to_tick, ov_tick}), 64'd0);
    cur_out = 32'd0; cur_freq = 32'd0; cur_ctrl = 8'd0; cur_hi = 8'd0; cur_lo = 8'd0;
    check_fields("rst");
    rst_ni = 1'b1;
    repeat (2) @(negedge clk);

    // Directed pack with literal expectations.
    pk = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hF0, 8'h00, 8'hFF, 8'h0F, 8'h01, 8'h05, 8'h14};
    cur_out = 32'h12345678; cur_freq = 32'h0FFF00F0; cur_ctrl = 8'h01; cur_hi = 8'd5; cur_lo = 8'd20;
    send_pack(0, 1'b1, "dir");

    pk[9] = 8'h00; pk[10] = 8'h00;
    send_pack(0, 1'b1, "zero_per");
    pk[9] = 8'h03; pk[10] = 8'h0A;
    cur_hi = 8'd3; cur_lo = 8'd10;
    send_pack(0, 1'b1, "small_per");

    for (int r = 0; r < 8; r++) begin
      rand_pack();
      model_pack();
      send_pack(0, 1'b1, "rand");
    end

    // Timeout after 6 bytes: pulse exactly TO_CLK clocks after the last byte.
    for (int i = 0; i < 6; i++) send_byte(8'($urandom), (i == 5) ? 0 : 1);
    first_n = -1;
    pulses = 0;
    bad = 0;
    for (int n = 1; n <= TO_CLK + 40; n++) begin
      @(negedge clk);
      if (to_tick) begin
        pulses++;
        if (first_n < 0) first_n = n;
      end
      if (valid) bad++;
    end
    check_eq("to_delay", 64'(first_n), 64'(TO_CLK));
    check_eq("to_pulses", 64'(pulses), 64'd1);
    check_eq("to_valid_low", 64'(bad), 64'd0);
    check_fields("to_keep");
    rand_pack();
    model_pack();
    send_pack(0, 1'b1, "after_to");

    // Overrun: extra byte while holding is dropped.
    rand_pack();
    model_pack();
    send_pack(0, 1'b0, "hold");
    send_byte(8'hA5, 0);
    check_eq("ov_pulse", 64'(ov_tick), 64'd1);
    bad = 0;
    ov_cnt = 0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (!valid || out_pat !== cur_out || freq_pat !== cur_freq ||
          ctrl !== cur_ctrl || hi !== cur_hi || lo !== cur_lo) bad++;
      if (ov_tick) ov_cnt++;
    end
    check_eq("hold_stable", 64'(bad), 64'd0);
    check_eq("ov_once", 64'(ov_cnt), 64'd0);
    ready = 1'b1;
    @(negedge clk);
    check_eq("hold_release", 64'(valid), 64'd0);
    rand_pack();
    model_pack();
    send_pack(0, 1'b1, "after_ov");

    // Handshake and next byte 0 in the same cycle.
    rand_pack();
    model_pack();
    send_pack(0, 1'b0, "same_a");
    rand_pack();
    @(negedge clk);
    data = pk[0];
    tick = 1'b1;
    ready = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    check_eq("same_valid_clr", 64'(valid), 64'd0);
    check_eq("same_no_ov", 64'(ov_tick), 64'd0);
    model_pack();
    send_pack(1, 1'b1, "same_b");

    // Reset mid-pack clears everything asynchronously.
    rand_pack();
    for (int i = 0; i < 8; i++) send_byte(pk[i], 1);
    #2;
    rst_ni = 1'b0;
    #1;
    cur_out = 32'd0; cur_freq = 32'd0; cur_ctrl = 8'd0; cur_hi = 8'd0; cur_lo = 8'd0;
    check_eq("arst_valid", 64'(valid), 64'd0);
    check_fields("arst");
    repeat (3) @(negedge clk);
    rst_ni = 1'b1;
    repeat (2) @(negedge clk);
    rand_pack();
    model_pack();
    send_pack(0, 1'b1, "after_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
